// File: rtl/gaussian_kernel_3x3.sv
// 3x3 Gaussian smoothing stage (1-2-1 / 2-4-2 / 1-2-1, /16 with rounding).
// Three-stage stall-free pipeline; frame-border pixels pass through unfiltered.
module gaussian_kernel_3x3 #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_vld,
    input  logic                  in_sof,
    input  logic [DATA_WIDTH-1:0] m11,
    input  logic [DATA_WIDTH-1:0] m12,
    input  logic [DATA_WIDTH-1:0] m13,
    input  logic [DATA_WIDTH-1:0] m21,
    input  logic [DATA_WIDTH-1:0] m22,
    input  logic [DATA_WIDTH-1:0] m23,
    input  logic [DATA_WIDTH-1:0] m31,
    input  logic [DATA_WIDTH-1:0] m32,
    input  logic [DATA_WIDTH-1:0] m33,
    output logic                  out_vld,
    output logic                  out_sof,
    output logic [DATA_WIDTH-1:0] out_data
);

    localparam int XW = $clog2(IMG_WIDTH);
    localparam int YW = $clog2(IMG_HEIGHT);
    localparam int RW = DATA_WIDTH + 2;
    localparam int TW = DATA_WIDTH + 4;
    localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

    function automatic logic [RW-1:0] row_sum(input logic [DATA_WIDTH-1:0] a,
                                              input logic [DATA_WIDTH-1:0] b,
                                              input logic [DATA_WIDTH-1:0] c);
        return RW'(a) + {1'b0, b, 1'b0} + RW'(c);
    endfunction

    // Round-half-up divide by 16; the +8 cannot carry out of TW bits.
    function automatic logic [DATA_WIDTH-1:0] round16(input logic [TW-1:0] t);
        logic [TW-1:0] s;
        s = t + TW'(8);
        return s[TW-1:4];
    endfunction

    logic [XW-1:0] r_x, w_x_cur, w_x_nxt;
    logic [YW-1:0] r_y, w_y_cur, w_y_nxt;
    logic          w_border;

    always_comb begin
        w_x_cur  = in_sof ? '0 : r_x;
        w_y_cur  = in_sof ? '0 : r_y;
        w_border = (w_x_cur == '0) || (w_x_cur == X_LAST) ||
                   (w_y_cur == '0) || (w_y_cur == Y_LAST);
        w_x_nxt  = w_x_cur + 1'b1;
        w_y_nxt  = w_y_cur;
        if (w_x_cur == X_LAST) begin
            w_x_nxt = '0;
            w_y_nxt = (w_y_cur == Y_LAST) ? '0 : w_y_cur + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x <= '0;
            r_y <= '0;
        end else if (in_vld) begin
            r_x <= w_x_nxt;
            r_y <= w_y_nxt;
        end
    end

    logic                  r_vld_p0, r_sof_p0, r_brd_p0;
    logic [RW-1:0]         r_r1_p0, r_r2_p0, r_r3_p0;
    logic [DATA_WIDTH-1:0] r_c_p0;
    logic                  r_vld_p1, r_sof_p1, r_brd_p1;
    logic [TW-1:0]         r_tot_p1;
    logic [DATA_WIDTH-1:0] r_c_p1;
    logic                  r_vld_p2, r_sof_p2;
    logic [DATA_WIDTH-1:0] r_data_p2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p0  <= 1'b0;
            r_sof_p0  <= 1'b0;
            r_brd_p0  <= 1'b0;
            r_r1_p0   <= '0;
            r_r2_p0   <= '0;
            r_r3_p0   <= '0;
            r_c_p0    <= '0;
            r_vld_p1  <= 1'b0;
            r_sof_p1  <= 1'b0;
            r_brd_p1  <= 1'b0;
            r_tot_p1  <= '0;
            r_c_p1    <= '0;
            r_vld_p2  <= 1'b0;
            r_sof_p2  <= 1'b0;
            r_data_p2 <= '0;
        end else begin
            // Stage 1: weighted row sums
            r_vld_p0 <= in_vld;
            r_sof_p0 <= in_vld & in_sof;
            r_brd_p0 <= w_border;
            r_r1_p0  <= row_sum(m11, m12, m13);
            r_r2_p0  <= row_sum(m21, m22, m23);
            r_r3_p0  <= row_sum(m31, m32, m33);
            r_c_p0   <= m22;
            // Stage 2: vertical weighting
            r_vld_p1 <= r_vld_p0;
            r_sof_p1 <= r_sof_p0;
            r_brd_p1 <= r_brd_p0;
            r_tot_p1 <= {2'b00, r_r1_p0} + {1'b0, r_r2_p0, 1'b0} + {2'b00, r_r3_p0};
            r_c_p1   <= r_c_p0;
            // Stage 3: normalise or pass the centre through; hold data on idle beats
            r_vld_p2 <= r_vld_p1;
            r_sof_p2 <= r_sof_p1;
            if (r_vld_p1)
                r_data_p2 <= r_brd_p1 ? r_c_p1 : round16(r_tot_p1);
        end
    end

    assign out_vld  = r_vld_p2;
    assign out_sof  = r_sof_p2;
    assign out_data = r_data_p2;

endmodule

// File: tb/tb_gaussian_kernel_3x3.sv
// Directed bench for gaussian_kernel_3x3 on a 4x3 image: vector table plus
// hand-written reset and early-SOF sequences, checked by a cycle-indexed scoreboard.
module tb_gaussian_kernel_3x3;

    typedef struct packed {
        logic            vld;
        logic            sof;
        logic [8:0][7:0] m;
        logic [7:0]      exp;
        logic            esof;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_vld = 1'b0;
    logic            in_sof = 1'b0;
    logic [8:0][7:0] tb_m = '0;
    logic            out_vld, out_sof;
    logic [7:0]      out_data;

    gaussian_kernel_3x3 #(.DATA_WIDTH(8), .IMG_WIDTH(4), .IMG_HEIGHT(3)) dut (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_sof(in_sof),
        .m11(tb_m[0]), .m12(tb_m[1]), .m13(tb_m[2]),
        .m21(tb_m[3]), .m22(tb_m[4]), .m23(tb_m[5]),
        .m31(tb_m[6]), .m32(tb_m[7]), .m33(tb_m[8]),
        .out_vld(out_vld), .out_sof(out_sof), .out_data(out_data)
    );

    always #5 clk = ~clk;

    int   pcnt = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    bit   chk_en = 1'b0;
    bit   exp_vld [0:1023];
    bit   exp_sof [0:1023];
    logic [7:0] exp_data [0:1023];
    logic [7:0] last_exp = 8'd0;
    vec_t tbl[$];

    always @(posedge clk) pcnt <= pcnt + 1;

    task automatic check(input string name, input int got, input int want);
        n_chk++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, pcnt, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check("out_vld", int'(out_vld), int'(exp_vld[pcnt]));
            if (exp_vld[pcnt]) begin
                check("out_data", int'(out_data), int'(exp_data[pcnt]));
                check("out_sof", int'(out_sof), int'(exp_sof[pcnt]));
                last_exp = exp_data[pcnt];
            end else begin
                check("out_data_hold", int'(out_data), int'(last_exp));
                check("out_sof_idle", int'(out_sof), 0);
            end
        end
    end

    function automatic vec_t mkv(input logic v, input logic s, input logic [71:0] m,
                                 input logic [7:0] e, input logic es);
        vec_t r;
        r.vld = v; r.sof = s; r.m = m; r.exp = e; r.esof = es;
        return r;
    endfunction

    function automatic logic [71:0] uni(input logic [7:0] v); return {9{v}}; endfunction
    function automatic logic [71:0] ctr(input logic [7:0] v); return {32'd0, v, 32'd0}; endfunction
    function automatic logic [71:0] c11(input logic [7:0] v); return {64'd0, v}; endfunction
    function automatic logic [71:0] c12(input logic [7:0] v); return {56'd0, v, 8'd0}; endfunction
    function automatic logic [71:0] c13(input logic [7:0] v); return {48'd0, v, 16'd0}; endfunction

    function automatic vec_t idle();
        return mkv(1'b0, 1'b1, uni(8'hAA), 8'd0, 1'b0);
    endfunction

    task automatic apply(input vec_t v);
        @(negedge clk);
        in_vld = v.vld;
        in_sof = v.sof;
        tb_m   = v.m;
        if (v.vld) begin
            exp_vld[pcnt+3]  = 1'b1;
            exp_data[pcnt+3] = v.exp;
            exp_sof[pcnt+3]  = v.esof;
        end
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        #1;
        rst    = 1'b1;
        in_vld = 1'b0;
        in_sof = 1'b0;
        for (int i = 1; i <= 6; i++) exp_vld[pcnt+i] = 1'b0;
        last_exp = 8'd0;
        #1;
        check("rst_out_vld", int'(out_vld), 0);
        check("rst_out_sof", int'(out_sof), 0);
        check("rst_out_data", int'(out_data), 0);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        // Frame A: flat image, every position returns 100
        tbl.push_back(mkv(1, 1, uni(100), 100, 1));
        for (int i = 1; i < 12; i++) tbl.push_back(mkv(1, 0, uni(100), 100, 0));
        // Frame B: border passthrough vs interior filtering
        tbl.push_back(mkv(1, 1, ctr(200), 200, 1));
        tbl.push_back(mkv(1, 0, ctr(255), 255, 0));
        tbl.push_back(mkv(1, 0, uni(7),   7,   0));
        tbl.push_back(mkv(1, 0, c11(16),  0,   0));
        tbl.push_back(mkv(1, 0, uni(255), 255, 0));
        tbl.push_back(mkv(1, 0, ctr(255), 64,  0));
        tbl.push_back(mkv(1, 0, c11(16),  1,   0));
        tbl.push_back(mkv(1, 0, ctr(200), 200, 0));
        tbl.push_back(mkv(1, 0, ctr(9),   9,   0));
        tbl.push_back(mkv(1, 0, ctr(2),   2,   0));
        tbl.push_back(mkv(1, 0, ctr(200), 200, 0));
        tbl.push_back(mkv(1, 0, uni(255), 255, 0));
        // Frame C: 200 at interior filters to 50; all-255 interior stays 255
        tbl.push_back(mkv(1, 1, uni(1),   1,   1));
        tbl.push_back(mkv(1, 0, ctr(5),   5,   0));
        tbl.push_back(mkv(1, 0, ctr(6),   6,   0));
        tbl.push_back(mkv(1, 0, ctr(7),   7,   0));
        tbl.push_back(mkv(1, 0, ctr(8),   8,   0));
        tbl.push_back(mkv(1, 0, ctr(200), 50,  0));
        tbl.push_back(mkv(1, 0, uni(255), 255, 0));
        tbl.push_back(mkv(1, 0, ctr(200), 200, 0));
        tbl.push_back(mkv(1, 0, c11(7),   0,   0));
        tbl.push_back(mkv(1, 0, ctr(2),   2,   0));
        tbl.push_back(mkv(1, 0, ctr(200), 200, 0));
        tbl.push_back(mkv(1, 0, ctr(3),   3,   0));
        // Frame D, back-to-back: idle gaps must not advance the position
        tbl.push_back(mkv(1, 1, ctr(11),  11,  1));
        tbl.push_back(mkv(1, 0, ctr(4),   4,   0));
        tbl.push_back(mkv(1, 0, ctr(5),   5,   0));
        tbl.push_back(mkv(1, 0, ctr(6),   6,   0));
        tbl.push_back(mkv(1, 0, ctr(7),   7,   0));
        tbl.push_back(idle());
        tbl.push_back(idle());
        tbl.push_back(mkv(1, 0, ctr(255), 64,  0));
        tbl.push_back(mkv(1, 0, c13(8),   1,   0));
        tbl.push_back(mkv(1, 0, ctr(1),   1,   0));
        tbl.push_back(idle());
        tbl.push_back(mkv(1, 0, ctr(20),  20,  0));
        tbl.push_back(mkv(1, 0, c12(4),   0,   0));
        tbl.push_back(mkv(1, 0, ctr(21),  21,  0));
        tbl.push_back(mkv(1, 0, ctr(22),  22,  0));
        for (int i = 0; i < 4; i++) tbl.push_back(idle());

        repeat (3) @(negedge clk);
        check("init_out_vld", int'(out_vld), 0);
        check("init_out_sof", int'(out_sof), 0);
        check("init_out_data", int'(out_data), 0);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // Reset with two beats still in the pipeline
        apply(mkv(1, 1, uni(50), 50, 1));
        for (int i = 1; i < 5; i++) apply(mkv(1, 0, uni(50), 50, 0));
        reset_pulse();
        repeat (2) apply(idle());
        apply(mkv(1, 1, ctr(77), 77, 1));
        for (int i = 1; i < 5; i++) apply(mkv(1, 0, ctr(8'(i)), 8'(i), 0));
        apply(mkv(1, 0, ctr(200), 50, 0));
        apply(mkv(1, 0, c12(4), 1, 0));
        for (int i = 7; i < 12; i++) apply(mkv(1, 0, ctr(8'(i)), 8'(i), 0));

        // Early SOF on the 7th beat restarts the position at (0,0)
        apply(mkv(1, 1, uni(30), 30, 1));
        for (int i = 1; i < 6; i++) apply(mkv(1, 0, uni(30), 30, 0));
        apply(mkv(1, 1, ctr(123), 123, 1));
        for (int i = 1; i < 5; i++) apply(mkv(1, 0, ctr(8'(i+40)), 8'(i+40), 0));
        apply(mkv(1, 0, ctr(200), 50, 0));
        apply(mkv(1, 0, ctr(123), 31, 0));
        repeat (6) apply(idle());

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
